// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with an iterative shift-add multiplier.
//
// Accepts one operation at a time on a valid/ready input handshake. It presents
// the registered result on a valid/ready output handshake. Single-cycle
// operations deliver one cycle after accept. MUL iterates for WIDTH cycles in
// the BUSY state before delivering.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   enable          gates acceptance of new operations only
//   in_valid        operand/opcode presented
//   in_ready        block can accept this cycle
//   opcode, A, B    operation select and operands, captured at accept
//   out_valid       result valid (HOLD state)
//   out_ready       consumer takes result
//   out             registered result
//   carry_flag      carry / borrow / nonzero high half of product
//   busy            multiply in progress
//   zero_flag, neg_flag, ovf_flag
//                   registered status flags, present only when the
//                   macro ALU_FLAGS_EN is defined
//
// Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 PASSA, 110 SHL, 111 MUL.

module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_flag,
  output logic             busy
`ifdef ALU_FLAGS_EN
  ,
  output logic             zero_flag,
  output logic             neg_flag,
  output logic             ovf_flag
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_PASSA = 3'b101;
  localparam logic [2:0] OP_SHL   = 3'b110;
  localparam logic [2:0] OP_MUL   = 3'b111;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t             state, state_next;
  logic               accept, is_mul, load_single, last_step;
  logic [2*WIDTH-1:0] mcand, acc, acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;
  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   alu_out, res_out;
  logic               alu_carry, res_carry;

  // A new operation may enter from IDLE, or from HOLD in the same cycle
  // that the held result is taken.
  assign in_ready    = enable && !rst &&
                       (state == IDLE || (state == HOLD && out_ready));
  assign accept      = in_valid && in_ready;
  assign is_mul      = (opcode == OP_MUL);
  assign load_single = accept && !is_mul;
  assign last_step   = (state == BUSY) && (count == LAST_COUNT);
  assign out_valid   = (state == HOLD);
  assign busy        = (state == BUSY);

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier LSB is set.
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  // The result register loads from the ALU on a single-cycle accept, or from
  // the final multiply step.
  assign res_out   = load_single ? alu_out : acc_next[WIDTH-1:0];
  assign res_carry = load_single ? alu_carry : (|acc_next[2*WIDTH-1:WIDTH]);

  // Single-cycle ALU operations.
  always_comb begin
    sum       = {1'b0, A} + {1'b0, B};
    diff      = {1'b0, A} - {1'b0, B};
    alu_out   = '0;
    alu_carry = 1'b0;
    case (opcode)
      OP_ADD:   begin alu_out = sum[WIDTH-1:0];  alu_carry = sum[WIDTH];  end
      OP_SUB:   begin alu_out = diff[WIDTH-1:0]; alu_carry = diff[WIDTH]; end
      OP_AND:   alu_out = A & B;
      OP_OR:    alu_out = A | B;
      OP_XOR:   alu_out = A ^ B;
      OP_PASSA: alu_out = A;
      OP_SHL:   begin alu_out = {A[WIDTH-2:0], 1'b0}; alu_carry = A[WIDTH-1]; end
      default:  ;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic alu_ovf;

  // Signed overflow: the result sign disagrees with the sign the operands imply.
  always_comb begin
    alu_ovf = 1'b0;
    if (opcode == OP_ADD)
      alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    else if (opcode == OP_SUB)
      alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
  end
`endif

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = is_mul ? BUSY : HOLD;
      BUSY: if (last_step) state_next = HOLD;
      HOLD: begin
        if (accept)         state_next = is_mul ? BUSY : HOLD;
        else if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Datapath: multiplier iteration and the result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out        <= '0;
      carry_flag <= 1'b0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      count      <= '0;
`ifdef ALU_FLAGS_EN
      zero_flag  <= 1'b0;
      neg_flag   <= 1'b0;
      ovf_flag   <= 1'b0;
`endif
    end else begin
      if (accept && is_mul) begin
        mcand  <= {{WIDTH{1'b0}}, A};
        mplier <= B;
        acc    <= '0;
        count  <= '0;
      end else if (state == BUSY) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + 1'b1;
      end

      if (load_single || last_step) begin
        out        <= res_out;
        carry_flag <= res_carry;
`ifdef ALU_FLAGS_EN
        zero_flag  <= (res_out == '0);
        neg_flag   <= res_out[WIDTH-1];
        ovf_flag   <= load_single && alu_ovf;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq at WIDTH=8.
// The stimulus pushes hand-computed results into a queue on issue. A monitor
// pops and compares the queue on every output handshake.

module tb_alu_seq;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             enable;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             carry_flag;
  logic             busy;
`ifdef ALU_FLAGS_EN
  logic             zero_flag;
  logic             neg_flag;
  logic             ovf_flag;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH:0] sb[$];

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .opcode(opcode),
    .A(A),
    .B(B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out(out),
    .carry_flag(carry_flag),
    .busy(busy)
`ifdef ALU_FLAGS_EN
    ,
    .zero_flag(zero_flag),
    .neg_flag(neg_flag),
    .ovf_flag(ovf_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation, wait (bounded) for in_ready, record the expected
  // result, and return one step after the accepting edge with junk operands.
  task automatic apply_stimulus(input logic [2:0] op, input logic [7:0] a,
                                input logic [7:0] b, input logic [7:0] exp_out,
                                input logic exp_carry, input bit push);
    int wait_cycles = 0;
    in_valid = 1'b1;
    opcode   = op;
    A        = a;
    B        = b;
    #1;
    while (!in_ready && wait_cycles < 50) begin
      @(posedge clk);
      #1;
      wait_cycles++;
    end
    if (!in_ready) check_output("accept_timeout", 32'(in_ready), 32'd1);
    if (push) sb.push_back({exp_carry, exp_out});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A        = 8'($urandom);
    B        = 8'($urandom);
  endtask

  task automatic wait_out_valid(input string name);
    int n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    if (!out_valid) check_output(name, 32'(out_valid), 32'd1);
  endtask

  // Monitor: compare every delivered result against the scoreboard.
  initial begin
    logic [WIDTH:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_output("unexpected_result", {23'd0, carry_flag, out}, 32'h1ff);
        end else begin
          e = sb.pop_front();
          check_output("sb_out", 32'(out), 32'(e[WIDTH-1:0]));
          check_output("sb_carry", 32'(carry_flag), 32'(e[WIDTH]));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen_valid;
    rst       = 1'b1;
    enable    = 1'b1;
    in_valid  = 1'b1;
    opcode    = 3'b000;
    A         = 8'h01;
    B         = 8'h01;
    out_ready = 1'b0;

    // Reset: in_ready must stay low even with a request pending.
    @(negedge clk);
    check_output("in_ready_in_reset", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check_output("rst_out", 32'(out), 32'h00);
    check_output("rst_carry", 32'(carry_flag), 32'd0);
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);

    // ADD with carry-out; held until taken, then back to IDLE.
    apply_stimulus(3'b000, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b1);
    check_output("add_valid", 32'(out_valid), 32'd1);
    check_output("add_out", 32'(out), 32'h10);
    check_output("add_carry", 32'(carry_flag), 32'd1);
    out_ready = 1'b1;
    tick();
    check_output("drain_valid", 32'(out_valid), 32'd0);
    check_output("drain_keeps_out", 32'(out), 32'h10);

    // Single-cycle ops, back-to-back.
    apply_stimulus(3'b001, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b1);
    apply_stimulus(3'b110, 8'h81, 8'h00, 8'h02, 1'b1, 1'b1);
    apply_stimulus(3'b101, 8'h5A, 8'h33, 8'h5A, 1'b0, 1'b1);
    apply_stimulus(3'b011, 8'hC0, 8'h0A, 8'hCA, 1'b0, 1'b1);
    apply_stimulus(3'b100, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b1);

    // MUL: exactly 8 busy cycles; operand changes during BUSY are ignored.
    apply_stimulus(3'b111, 8'h10, 8'h20, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check_output("mul_busy", 32'(busy), 32'd1);
      check_output("mul_no_valid", 32'(out_valid), 32'd0);
      if (i == 3) begin
        A = 8'hFF;
        B = 8'hFF;
      end
      tick();
    end
    check_output("mul_busy_done", 32'(busy), 32'd0);
    check_output("mul_valid", 32'(out_valid), 32'd1);
    tick();

    // Backpressure: result held, in_ready low.
    out_ready = 1'b0;
    apply_stimulus(3'b000, 8'h01, 8'h02, 8'h03, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check_output("bp_out", 32'(out), 32'h03);
      check_output("bp_valid", 32'(out_valid), 32'd1);
      check_output("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    apply_stimulus(3'b010, 8'hCC, 8'hAA, 8'h88, 1'b0, 1'b1);
    check_output("b2b_valid", 32'(out_valid), 32'd1);
    check_output("b2b_out", 32'(out), 32'h88);

    // enable=0 mid-multiply: multiply still completes and delivers.
    apply_stimulus(3'b111, 8'h0D, 8'h0B, 8'h8F, 1'b0, 1'b1);
    tick();
    tick();
    enable = 1'b0;
    wait_out_valid("mul_en0_timeout");
    check_output("en0_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    opcode   = 3'b000;
    A        = 8'hFF;
    B        = 8'h02;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("en0_blocked", 32'(in_ready), 32'd0);
    end
    sb.push_back({1'b1, 8'h01});
    enable = 1'b1;
    tick();
    in_valid = 1'b0;
    check_output("en1_valid", 32'(out_valid), 32'd1);
    check_output("en1_out", 32'(out), 32'h01);

    // Reset during BUSY: aborted, nothing delivered.
    apply_stimulus(3'b111, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    check_output("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_valid", 32'(out_valid), 32'd0);
    check_output("abort_out", 32'(out), 32'h00);
    check_output("abort_carry", 32'(carry_flag), 32'd0);
    seen_valid = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen_valid++;
      tick();
    end
    check_output("abort_no_delivery", 32'(seen_valid), 32'd0);

    // Full multiply with both halves nonzero.
    apply_stimulus(3'b111, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b1);
    wait_out_valid("mul_ff_timeout");
    tick();

    // Signed-overflow case.
    out_ready = 1'b0;
    apply_stimulus(3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    check_output("ovf_out", 32'(out), 32'h80);
`ifdef ALU_FLAGS_EN
    check_output("ovf_flag", 32'(ovf_flag), 32'd1);
    check_output("neg_flag", 32'(neg_flag), 32'd1);
    check_output("zero_flag", 32'(zero_flag), 32'd0);
`endif
    out_ready = 1'b1;
    tick();
    tick();
    check_output("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
